// File: rtl/mod47_residue_accumulator_if.sv
// Valid/ready stream bundle between the residue LUT bank, the mod-47
// accumulator and the downstream residue-to-binary converter.
interface mod47_residue_accumulator_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_residue;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_residue;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  modport slave (
    input  in_valid, in_residue, in_last, out_ready,
    output in_ready, out_valid, out_residue, out_count, out_err
  );

  modport master (
    output in_valid, in_residue, in_last, out_ready,
    input  in_ready, out_valid, out_residue, out_count, out_err
  );
endinterface

// File: rtl/mod47_residue_accumulator.sv
// Sums a framed stream of residues modulo MODULUS and emits one reduced
// residue, beat count and range-error flag per frame.
module mod47_residue_accumulator #(
  parameter int MODULUS = 47,
  parameter int WIDTH   = 6,
  parameter int MAX_LEN = 300,
  parameter int CNT_W   = 9
) (
  input logic                         clk,
  input logic                         rst,
  mod47_residue_accumulator_if.slave  bus
);

  typedef enum logic {ACC, OUT} state_t;

  localparam logic [WIDTH-1:0] MOD_R = WIDTH'(MODULUS);
  localparam logic [WIDTH:0]   MOD_S = (WIDTH+1)'(MODULUS);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, r, acc_next;
  logic [WIDTH:0]   s;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             err, violation;
  logic             in_ready, xfer, close;
  logic [WIDTH-1:0] out_residue;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  // Operands 47..63 fold back into 0..16 and mark the frame as erroneous.
  always_comb begin
    violation = (bus.in_residue >= MOD_R);
    r         = violation ? (bus.in_residue - MOD_R) : bus.in_residue;
    s         = {1'b0, acc} + {1'b0, r};
    acc_next  = WIDTH'((s >= MOD_S) ? (s - MOD_S) : s);
    cnt_inc   = cnt + ONE_C;
  end

  // out_ready feeds in_ready combinationally so a retiring result and a
  // closing beat can share a cycle.
  assign in_ready = (state == ACC) || bus.out_ready;
  assign xfer     = bus.in_valid && in_ready;
  assign close    = xfer && (bus.in_last || (cnt_inc == LEN_C));

  // NOTE: every signal driven in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    state_next = state;
    if (close)
      state_next = OUT;
    else if ((state == OUT) && bus.out_ready)
      state_next = ACC;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      out_residue <= '0;
      out_count   <= '0;
      out_err     <= 1'b0;
    end else if (xfer) begin
      if (close) begin
        out_residue <= acc_next;
        out_count   <= cnt_inc;
        out_err     <= err | violation;
        acc         <= '0;
        cnt         <= '0;
        err         <= 1'b0;
      end else begin
        acc <= acc_next;
        cnt <= cnt_inc;
        err <= err | violation;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state == OUT);
  assign bus.out_residue = out_residue;
  assign bus.out_count   = out_count;
  assign bus.out_err     = out_err;

endmodule

// File: tb/tb_mod47_residue_accumulator.sv
// Directed and randomized bench for mod47_residue_accumulator against a
// frame-level arithmetic model.
module tb_mod47_residue_accumulator;

  localparam int MODULUS = 47;
  localparam int WIDTH   = 6;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 9;

  typedef struct {
    int residue;
    int count;
    int err;
  } result_t;

  logic clk;
  logic rst;
  logic rand_ready;
  logic ready_req;
  int   n_tests;
  int   n_fail;

  result_t log_q[$];
  int      frame_q[$];
  bit      m_valid;
  int      m_res, m_cnt, m_err;
  bit      exp_ready;
  bit      hold_pend;
  int      held_res;
  bit      held_last;
  int      sum;
  bit      ferr;

  mod47_residue_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  mod47_residue_accumulator #(
    .MODULUS(MODULUS),
    .WIDTH  (WIDTH),
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expect_log(input int idx, input int res, input int cnt, input int err);
    if (idx < log_q.size()) begin
      check("lit_residue", log_q[idx].residue, res);
      check("lit_count",   log_q[idx].count,   cnt);
      check("lit_err",     log_q[idx].err,     err);
    end else begin
      check("lit_missing", log_q.size(), idx + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v, input bit last);
    int waited;
    bus.in_valid   = 1'b1;
    bus.in_residue = WIDTH'(v);
    bus.in_last    = last;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 100) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_now_out_valid",   bus.out_valid,   0);
    check("rst_now_out_residue", bus.out_residue, 0);
    check("rst_now_out_count",   bus.out_count,   0);
    check("rst_now_out_err",     bus.out_err,     0);
    check("rst_now_in_ready",    bus.in_ready,    1);
  endtask

  // Reference: a frame is the list of accepted operands; its result is the
  // plain sum of the folded operands taken mod MODULUS.
  always @(negedge clk) begin
    if (rst) begin
      m_valid   = 1'b0;
      hold_pend = 1'b0;
      frame_q.delete();
      check("rst_out_valid",   bus.out_valid,   0);
      check("rst_out_residue", bus.out_residue, 0);
      check("rst_out_count",   bus.out_count,   0);
      check("rst_out_err",     bus.out_err,     0);
    end else begin
      exp_ready = !m_valid || bus.out_ready;
      check("in_ready",  bus.in_ready,  exp_ready);
      check("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        check("out_residue", bus.out_residue, m_res);
        check("out_count",   bus.out_count,   m_cnt);
        check("out_err",     bus.out_err,     m_err);
      end
      if (hold_pend)
        assert (bus.in_valid && int'(bus.in_residue) == held_res && bus.in_last == held_last)
          else $error("stalled input beat changed before transfer");
      hold_pend = bus.in_valid && !bus.in_ready;
      held_res  = int'(bus.in_residue);
      held_last = bus.in_last;
      if (bus.out_valid && bus.out_ready)
        log_q.push_back('{int'(bus.out_residue), int'(bus.out_count), int'(bus.out_err)});
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (bus.in_valid && exp_ready) begin
        frame_q.push_back(int'(bus.in_residue));
        if (bus.in_last || frame_q.size() == MAX_LEN) begin
          sum  = 0;
          ferr = 1'b0;
          foreach (frame_q[i]) begin
            if (frame_q[i] >= MODULUS) begin
              sum += frame_q[i] - MODULUS;
              ferr = 1'b1;
            end else begin
              sum += frame_q[i];
            end
          end
          m_res   = sum % MODULUS;
          m_cnt   = frame_q.size();
          m_err   = int'(ferr);
          m_valid = 1'b1;
          frame_q.delete();
        end
      end
    end
  end

  initial begin
    int base;
    int v;
    bit last;
    n_tests        = 0;
    n_fail         = 0;
    rand_ready     = 1'b0;
    ready_req      = 1'b0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_residue = '0;
    bus.in_last    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    ready_req = 1'b1;
    idle(1);

    base = log_q.size();
    send(46, 0); send(1, 1);
    send(30, 0); send(30, 0); send(30, 1);
    send(0, 1);
    idle(3);
    expect_log(base,     0,  2, 0);
    expect_log(base + 1, 43, 3, 0);
    expect_log(base + 2, 0,  1, 0);

    base = log_q.size();
    send(50, 0); send(10, 1);
    send(5, 1);
    idle(3);
    expect_log(base,     13, 2, 1);
    expect_log(base + 1, 5,  1, 0);

    base      = log_q.size();
    ready_req = 1'b0;
    send(8, 1);
    bus.in_valid   = 1'b1;
    bus.in_residue = WIDTH'(7);
    bus.in_last    = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready",    bus.in_ready,    0);
      check("bp_out_valid",   bus.out_valid,   1);
      check("bp_out_residue", bus.out_residue, 8);
      check("bp_out_count",   bus.out_count,   1);
    end
    @(posedge clk);
    #1;
    ready_req = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check("bp_next_out_valid",   bus.out_valid,   1);
    check("bp_next_out_residue", bus.out_residue, 7);
    idle(2);
    expect_log(base,     8, 1, 0);
    expect_log(base + 1, 7, 1, 0);

    base = log_q.size();
    send(20, 0); send(20, 0); send(20, 0); send(20, 0);
    send(1, 1);
    idle(3);
    expect_log(base,     33, 4, 0);
    expect_log(base + 1, 1,  1, 0);

    ready_req = 1'b0;
    send(9, 1);
    idle(2);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    idle(2);
    rst       = 1'b0;
    ready_req = 1'b1;
    idle(1);

    send(40, 0); send(40, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    idle(2);
    rst = 1'b0;
    idle(1);
    base = log_q.size();
    send(12, 1);
    idle(3);
    expect_log(base, 12, 1, 0);

    rand_ready = 1'b1;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 7) == 0) v = int'($urandom_range(47, 63));
      else                           v = int'($urandom_range(0, 46));
      last = ($urandom_range(0, 3) == 0);
      send(v, last);
    end
    rand_ready = 1'b0;
    ready_req  = 1'b1;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
